pattern_packet_tx: RTL
======================

Name: pattern_packet_tx

Overview:
- Host-side packet sender for the differential-frequency serial output channels; produces the 9-byte command packets that `diff_freq_serial_out` consumes.
- Snapshots a 32-bit output pattern, a 32-bit frequency pattern and an 8-bit control byte, then serializes them byte by byte into a UART transmitter through its start/done handshake.
- Sits between the command source (register bank or test sequencer) and the `UART` TX interface (`i_tx_start` / `i_tx_data` / `o_tx_done_tick`).

Parameters:
- DATA_BIT, 32, width of each pattern field; must be a multiple of 8.
- PACK_NUM, 9, bytes per packet, equal to (2*DATA_BIT+8)/8.
- GAP_CLK, 0, idle clocks inserted after each `i_tx_done_tick` before the next byte's `o_tx_start`.
- TIMEOUT_CLK, 20000, maximum clocks to wait for `i_tx_done_tick` per byte.
- TO_BIT, 15, counter width; must be >= log2(TIMEOUT_CLK+1) and >= log2(GAP_CLK+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- i_start  in  1  one-clock request to send a packet.
- i_out_pattern  in  DATA_BIT  output pattern.
- i_freq_pattern  in  DATA_BIT  frequency pattern.
- i_ctrl  in  8  control byte: [7:4] channel, [3] reserved 0, [2] mode (0 one-shot, 1 repeat), [1:0] speed code.
- o_tx_start  out  1  one-clock start pulse to UART TX.
- o_tx_data  out  8  byte to UART TX; held stable from the `o_tx_start` cycle until `i_tx_done_tick`.
- i_tx_done_tick  in  1  UART TX byte-complete tick.
- o_busy  out  1  packet in progress.
- o_done_tick  out  1  one clock: packet fully sent.
- o_err_tick  out  1  one clock: timeout abort.

Behaviour:
- Single clock `clk`; reset is synchronous and active-low on `rst_n`.
- Reset values:
  - `o_tx_start`, `o_busy`, `o_done_tick` and `o_err_tick` are 0.
  - `o_tx_data` is 8'h00.
  - State is IDLE; byte index and counters are 0.
- Reset asserted mid-packet aborts the packet immediately. No `o_done_tick` or `o_err_tick` is issued.
- Packet byte order:
  - Bytes 0-3: `i_out_pattern[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
  - Bytes 4-7: `i_freq_pattern`, in the same low-byte-first order.
  - Byte 8: `i_ctrl`.
  - All three inputs are snapshotted into a PACK_NUM*8 shift register on the accepting clock. Later input changes do not affect the packet in flight.
- FSM states: IDLE, SEND, WAIT, GAP, DONE.
  - IDLE: `i_start`=1 captures the inputs, clears the byte index and moves to SEND. `o_busy` rises on the next clock.
  - SEND: `o_tx_start`=1 for exactly one clock with `o_tx_data`=byte[index]. Clear the timeout counter and go to WAIT. The first `o_tx_start` occurs 1 clock after accepted `i_start`.
  - WAIT: the timeout counter increments each clock.
    - On `i_tx_done_tick`: if index = PACK_NUM-1, go to DONE. Otherwise increment the index and go to GAP, or go straight to SEND when GAP_CLK=0. With GAP_CLK=0 the next `o_tx_start` is 1 clock after `i_tx_done_tick`.
    - If the counter reaches TIMEOUT_CLK with no tick, pulse `o_err_tick` and go to IDLE.
    - If `i_tx_done_tick` arrives in the same clock the counter reaches TIMEOUT_CLK, the done tick wins and no error is raised.
  - GAP: count GAP_CLK clocks, then go to SEND.
  - DONE: `o_done_tick`=1 for one clock, then go to IDLE.
- `o_busy` is 1 in SEND, WAIT, GAP and DONE. It is 0 in IDLE, including the clock `o_err_tick` is high.
- `i_start` while `o_busy`=1 is ignored; there is no queueing.
- `i_tx_done_tick` outside WAIT is ignored. This includes a tick in the same clock as `o_tx_start`.
- `o_tx_data` retains the last byte sent while in IDLE.
- Exactly PACK_NUM `o_tx_start` pulses occur per successful packet.

Test Plan:
- Basic packet. Stimulus: reset, then `i_start` with out=32'h00FF00FF, freq=0, ctrl=8'h05, and the UART model returning `i_tx_done_tick` 10 clocks after each start. Response: bytes FF,00,FF,00,00,00,00,00,05 in order; `o_done_tick` 1 clock after the 9th done tick; `o_busy` low afterwards.
- Snapshot. Stimulus: change `i_out_pattern` to 32'h12345678 one clock after `i_start`. Response: the packet still carries FF,00,FF,00.
- Ignored start and gap timing. Stimulus: GAP_CLK=3, with `i_start` pulsed during byte 4. Response: one packet only; `o_tx_start` occurs 4 clocks after each `i_tx_done_tick`.
- Timeout. Stimulus: TIMEOUT_CLK=50, suppress the done tick for byte 2. Response: `o_err_tick` 50 clocks after byte 2's `o_tx_start`; no `o_done_tick`; the next `i_start` sends a full 9-byte packet.
- Simultaneous done and timeout. Stimulus: done tick asserted exactly at clock 50. Response: no error; the packet completes.
- Mid-packet reset. Stimulus: `rst_n`=0 for 1 clock during byte 6. Response: all outputs at reset values on the next clock; no done or error tick.

Source files
------------

// File: rtl/pattern_packet_tx.sv
// pattern_packet_tx: snapshots two pattern words plus a control byte and feeds them byte by byte to a UART TX
module pattern_packet_tx #(
  parameter int DATA_BIT    = 32,
  parameter int PACK_NUM    = 9,
  parameter int GAP_CLK     = 0,
  parameter int TIMEOUT_CLK = 20000,
  parameter int TO_BIT      = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [DATA_BIT-1:0] i_out_pattern,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic [7:0]          i_ctrl,
  output logic                o_tx_start,
  output logic [7:0]          o_tx_data,
  input  logic                i_tx_done_tick,
  output logic                o_busy,
  output logic                o_done_tick,
  output logic                o_err_tick
);
  localparam int SW = PACK_NUM * 8;
  localparam int IW = $clog2(PACK_NUM);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TO_BIT-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SW-1:0] sr_q, sr_d;
  logic err_q, err_d;
  assign cnt_inc     = cnt_q + 1'b1;
  assign o_tx_start  = state_q == SEND;
  assign o_busy      = state_q != IDLE;
  assign o_done_tick = state_q == DONE;
  assign o_err_tick  = err_q;
  // low byte of the snapshot is always the byte on the wire; it only shifts on a non-final done tick so the last byte stays visible in IDLE
  assign o_tx_data   = sr_q[7:0];
  // next-state: the counter holds clocks since o_tx_start in WAIT and clocks spent in GAP; a done tick beats a same-clock timeout
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = SEND;
        idx_d   = '0;
        sr_d    = {i_ctrl, i_freq_pattern, i_out_pattern};
      end
      SEND: begin
        state_d = WAIT;
        cnt_d   = TO_BIT'(1);
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (i_tx_done_tick) begin
          if (idx_q == IW'(PACK_NUM - 1)) state_d = DONE;
          else begin
            idx_d   = idx_q + 1'b1;
            sr_d    = sr_q >> 8;
            cnt_d   = '0;
            state_d = GAP_CLK == 0 ? SEND : GAP;
          end
        end else if (cnt_inc == TO_BIT'(TIMEOUT_CLK)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        cnt_d = cnt_inc;
        if (cnt_inc == TO_BIT'(GAP_CLK)) state_d = SEND;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset; reset drops any packet in flight silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      err_q   <= err_d;
    end
  end
endmodule
